// File: rtl/smvm_issue_sched.sv
// Sparse-matrix issue scheduler: packs nonzero beats into K-lane groups, at least GAP cycles between issues.
// A group appears 1 cycle after its closing beat and holds under iss_ready backpressure; nz_ready is high only in FILL.
module smvm_issue_sched #(
  parameter int K   = 4,
  parameter int W   = 8,
  parameter int GAP = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           nz_valid,
  output logic           nz_ready,
  input  logic [W-1:0]   nz_val,
  input  logic [W-1:0]   nz_col,
  input  logic           nz_ipv,
  input  logic           nz_last,
  output logic           iss_valid,
  input  logic           iss_ready,
  output logic [K*W-1:0] iss_val,
  output logic [K*W-1:0] iss_col,
  output logic [K-1:0]   iss_ipv,
  output logic [2:0]     iss_cnt,
  output logic [7:0]     rows_done,
  output logic           done,
  output logic           busy
);

  localparam int CW     = $clog2(K + 1);
  localparam int GAP_LD = (GAP > 1) ? GAP - 2 : 0;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         state, nxt;
  logic [W-1:0]   lane_val [K];
  logic [W-1:0]   lane_col [K];
  logic [K-1:0]   lane_ipv;
  logic [CW-1:0]  lane_cnt;
  logic           last_flg;
  logic [3:0]     gap_cnt;
  logic           accept, hs, lane_full;
  logic [8:0]     ipv_pop, rows_sum;

  assign accept    = (state == S_FILL) && nz_valid;
  assign hs        = (state == S_ISSUE) && iss_ready;
  assign lane_full = (lane_cnt == CW'(K - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_FILL;
      S_FILL:  if (accept && (lane_full || nz_last)) nxt = S_ISSUE;
      S_ISSUE: if (hs) nxt = last_flg ? S_DONE : ((GAP == 1) ? S_FILL : S_WAIT);
      S_WAIT:  if (gap_cnt == 4'd0) nxt = S_FILL;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    nz_ready  = (state == S_FILL);
    iss_valid = (state == S_ISSUE);
    done      = (state == S_DONE);
    busy      = (state != S_IDLE);
    iss_cnt   = (state == S_ISSUE) ? 3'(lane_cnt) : 3'd0;
    iss_val   = '0;
    iss_col   = '0;
    iss_ipv   = '0;
    if (state == S_ISSUE) begin
      // lane 0 occupies the most-significant slice
      for (int i = 0; i < K; i++) begin
        iss_val[(K-1-i)*W +: W] = lane_val[i];
        iss_col[(K-1-i)*W +: W] = lane_col[i];
        iss_ipv[K-1-i]          = lane_ipv[i];
      end
    end
  end

  always_comb begin
    ipv_pop = '0;
    for (int i = 0; i < K; i++) ipv_pop = ipv_pop + 9'(lane_ipv[i]);
    rows_sum = {1'b0, rows_done} + ipv_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_done <= '0;
      lane_cnt  <= '0;
      last_flg  <= 1'b0;
      gap_cnt   <= '0;
      lane_ipv  <= '0;
      for (int i = 0; i < K; i++) begin
        lane_val[i] <= '0;
        lane_col[i] <= '0;
      end
    end else begin
      if (state == S_IDLE && start) begin
        rows_done <= '0;
        lane_cnt  <= '0;
        last_flg  <= 1'b0;
        lane_ipv  <= '0;
        for (int i = 0; i < K; i++) begin
          lane_val[i] <= '0;
          lane_col[i] <= '0;
        end
      end
      if (accept) begin
        for (int i = 0; i < K; i++) begin
          if (lane_cnt == CW'(i)) begin
            lane_val[i] <= nz_val;
            lane_col[i] <= nz_col;
            lane_ipv[i] <= nz_ipv | nz_last;
          end
        end
        lane_cnt <= lane_cnt + 1'b1;
        if (nz_last) last_flg <= 1'b1;
      end
      // clearing lanes on issue keeps unoccupied lanes of a partial group at zero
      if (hs) begin
        rows_done <= (rows_sum > 9'd255) ? 8'hFF : rows_sum[7:0];
        lane_cnt  <= '0;
        lane_ipv  <= '0;
        gap_cnt   <= 4'(GAP_LD);
        for (int i = 0; i < K; i++) begin
          lane_val[i] <= '0;
          lane_col[i] <= '0;
        end
      end
      if (state == S_WAIT && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_smvm_issue_sched.sv
// Directed bench for smvm_issue_sched (K=4, W=8, GAP=4): vector table plus multi-cycle sequences.
module tb_smvm_issue_sched;

  logic        clk = 1'b0;
  logic        rst, start, nz_valid, nz_ready, nz_ipv, nz_last;
  logic [7:0]  nz_val, nz_col;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_val, iss_col;
  logic [3:0]  iss_ipv;
  logic [2:0]  iss_cnt;
  logic [7:0]  rows_done;
  logic        done, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  smvm_issue_sched #(.K(4), .W(8), .GAP(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val), .nz_col(nz_col),
    .nz_ipv(nz_ipv), .nz_last(nz_last),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_val(iss_val), .iss_col(iss_col),
    .iss_ipv(iss_ipv), .iss_cnt(iss_cnt), .rows_done(rows_done), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic rst, start, nzv;
    logic [7:0] val, col;
    logic ipv, last, irdy;
    logic e_nrdy, e_ivld;
    logic [31:0] e_ival, e_icol;
    logic [3:0] e_iipv;
    logic [2:0] e_icnt;
    logic [7:0] e_rows;
    logic e_done, e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] vl, logic [7:0] cl,
                              logic ip, logic la, logic ir, logic enr, logic eiv,
                              logic [31:0] evl, logic [31:0] ecl, logic [3:0] eip,
                              logic [2:0] ecn, logic [7:0] erw, logic edn, logic ebs);
    vec_t t;
    t.rst = r; t.start = s; t.nzv = v; t.val = vl; t.col = cl; t.ipv = ip; t.last = la;
    t.irdy = ir; t.e_nrdy = enr; t.e_ivld = eiv; t.e_ival = evl; t.e_icol = ecl;
    t.e_iipv = eip; t.e_icnt = ecn; t.e_rows = erw; t.e_done = edn; t.e_busy = ebs;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out at cycle %0d", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] v, input logic [7:0] c, input logic ip, input logic la);
    int n = 0;
    nz_valid = 1'b1; nz_val = v; nz_col = c; nz_ipv = ip; nz_last = la;
    while (!nz_ready && n < 64) begin tick(); n++; end
    if (!nz_ready) timeout_fail("beat_accept");
    else tick();
    nz_valid = 1'b0; nz_last = 1'b0; nz_ipv = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!iss_valid && n < 64) begin tick(); n++; end
    if (!iss_valid) timeout_fail("issue_wait");
  endtask

  task automatic handshake(output int hs_cyc);
    iss_ready = 1'b1;
    hs_cyc = cyc + 1;
    tick();
    iss_ready = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 64) begin tick(); n++; end
    if (!done) timeout_fail("done_wait");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int hs1, hs2, dn;
    rst = 1'b1; start = 1'b0; nz_valid = 1'b0; nz_val = '0; nz_col = '0;
    nz_ipv = 1'b0; nz_last = 1'b0; iss_ready = 1'b0;
    tick(); tick();
    chk("reset_state", {nz_ready, iss_valid, iss_val, iss_col, iss_ipv, iss_cnt, rows_done, done, busy}, '0);
    rst = 1'b0;

    // full group, gap, single-beat last group, then rst beating start in IDLE
    tbl.push_back(mk(0,1,0,8'h00,8'h00,0,0,0, 0,0,32'h0,32'h0,4'b0000,0,0,0,0));
    tbl.push_back(mk(0,0,1,8'h01,8'h00,0,0,0, 1,0,32'h0,32'h0,4'b0000,0,0,0,1));
    tbl.push_back(mk(0,0,1,8'h02,8'h01,1,0,0, 1,0,32'h0,32'h0,4'b0000,0,0,0,1));
    tbl.push_back(mk(0,0,1,8'h03,8'h02,0,0,0, 1,0,32'h0,32'h0,4'b0000,0,0,0,1));
    tbl.push_back(mk(0,0,1,8'h04,8'h03,1,0,0, 1,0,32'h0,32'h0,4'b0000,0,0,0,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,1, 0,1,32'h01020304,32'h00010203,4'b0101,4,0,0,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0, 0,0,32'h0,32'h0,4'b0000,0,2,0,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0, 0,0,32'h0,32'h0,4'b0000,0,2,0,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0, 0,0,32'h0,32'h0,4'b0000,0,2,0,1));
    tbl.push_back(mk(0,0,1,8'h05,8'h04,0,1,0, 1,0,32'h0,32'h0,4'b0000,0,2,0,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,1, 0,1,32'h05000000,32'h04000000,4'b1000,1,2,0,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0, 0,0,32'h0,32'h0,4'b0000,0,3,1,1));
    tbl.push_back(mk(1,1,0,8'h00,8'h00,0,0,0, 0,0,32'h0,32'h0,4'b0000,0,3,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0, 0,0,32'h0,32'h0,4'b0000,0,0,0,0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; start = tbl[i].start; nz_valid = tbl[i].nzv; nz_val = tbl[i].val;
      nz_col = tbl[i].col; nz_ipv = tbl[i].ipv; nz_last = tbl[i].last; iss_ready = tbl[i].irdy;
      #1;
      chk($sformatf("vec%0d", i),
          {nz_ready, iss_valid, iss_val, iss_col, iss_ipv, iss_cnt, rows_done, done, busy},
          {tbl[i].e_nrdy, tbl[i].e_ivld, tbl[i].e_ival, tbl[i].e_icol, tbl[i].e_iipv,
           tbl[i].e_icnt, tbl[i].e_rows, tbl[i].e_done, tbl[i].e_busy});
      tick();
    end
    rst = 1'b0; start = 1'b0; nz_valid = 1'b0; nz_last = 1'b0; nz_ipv = 1'b0; iss_ready = 1'b0;

    // partial flush with backpressure on the first group
    pulse_start();
    beat(8'h11, 8'h01, 0, 0); beat(8'h12, 8'h02, 0, 0);
    beat(8'h13, 8'h03, 0, 0); beat(8'h14, 8'h04, 0, 0);
    wait_issue();
    nz_valid = 1'b1; nz_val = 8'h15; nz_col = 8'h05;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), {iss_valid, nz_ready, iss_val, iss_col, iss_ipv, iss_cnt},
          {1'b1, 1'b0, 32'h11121314, 32'h01020304, 4'b0000, 3'd4});
      tick();
    end
    handshake(hs1);
    beat(8'h15, 8'h05, 0, 0);
    beat(8'h16, 8'h06, 0, 1);
    wait_issue();
    chk("flush_group", {iss_val, iss_col, iss_ipv, iss_cnt},
        {32'h15160000, 32'h05060000, 4'b0100, 3'd2});
    handshake(hs2);
    checks++;
    if (hs2 - hs1 < 4) begin
      errors++;
      $display("FAIL hs_gap got %0d cycles want at least 4", hs2 - hs1);
    end
    chk("done_after_hs", done, 1);
    dn = int'(done);
    for (int k = 0; k < 4; k++) begin tick(); dn += int'(done); end
    chk("done_once", dn, 1);
    chk("flush_rows", rows_done, 8'd1);

    // reset mid-operation, after one group has already counted rows
    pulse_start();
    for (int k = 0; k < 4; k++) beat(8'h20 + 8'(k), 8'(k), 1, 0);
    wait_issue();
    handshake(hs1);
    for (int k = 0; k < 3; k++) beat(8'h21, 8'h01, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_idle", {iss_valid, rows_done, busy, nz_ready}, '0);
    pulse_start();
    beat(8'h33, 8'h03, 0, 1);
    wait_issue();
    chk("midrst_single", {iss_cnt, iss_val, iss_ipv}, {3'd1, 32'h33000000, 4'b1000});
    handshake(hs1);
    wait_done();

    // saturation, with start pulses late in the matrix that must be ignored
    tick();
    pulse_start();
    iss_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      start = (i >= 290 && i < 296);
      beat(8'(i), 8'(i), 1, (i == 300));
    end
    start = 1'b0;
    wait_done();
    chk("sat_rows", rows_done, 8'd255);
    iss_ready = 1'b0;
    tick();
    chk("sat_hold", {busy, rows_done}, {1'b0, 8'd255});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
